// File: rtl/ram_controller.sv
// Byte-addressed RAM serving the ALU memory port with programmable wait states.
// Define RAM_BOUNDS_CHECK_EN to flag out-of-range accesses via busError.
module ram_controller #(
  parameter int    ADDR_WIDTH  = 11,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ramAddress,
  input  logic [31:0] ramIn,
  input  logic        readReq,
  input  logic        writeReq,
  output logic [31:0] ramValue,
  output logic        readAck,
  output logic        writeAck,
  output logic        busError
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, ACCESS, ACK} stateT;

  logic [7:0]            mem [DEPTH];
  stateT                 state;
  logic [7:0]            waitCnt;
  logic [ADDR_WIDTH-1:0] addrReg;
  logic [31:0]           dataReg;
  logic                  opWrite;
  logic                  outOfRange;
  logic                  reqOutOfRange;
  logic [ADDR_WIDTH-1:0] lane [4];

`ifdef RAM_BOUNDS_CHECK_EN
  logic [32:0] lastByte;
  assign lastByte      = {1'b0, ramAddress} + 33'd3;
  assign reqOutOfRange = (lastByte >= 33'(DEPTH));
`else
  logic unusedHiBits;
  assign unusedHiBits  = ^ramAddress[31:ADDR_WIDTH];
  assign reqOutOfRange = 1'b0;
`endif

  // Byte lanes wrap naturally because the lane address is only ADDR_WIDTH bits wide.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane[i] = addrReg + ADDR_WIDTH'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ramValue <= 32'h0;
      readAck  <= 1'b0;
      writeAck <= 1'b0;
      busError <= 1'b0;
      waitCnt  <= 8'd0;
    end else begin
      readAck  <= 1'b0;
      writeAck <= 1'b0;
      busError <= 1'b0;
      case (state)
        IDLE: begin
          if (readReq || writeReq) begin
            addrReg    <= ramAddress[ADDR_WIDTH-1:0];
            dataReg    <= ramIn;
            opWrite    <= writeReq;
            outOfRange <= reqOutOfRange;
            waitCnt    <= 8'(WAIT_CYCLES);
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (waitCnt == 8'd0) state <= ACCESS;
          else                 waitCnt <= waitCnt - 8'd1;
        end
        ACCESS: begin
          if (!opWrite) begin
            ramValue <= outOfRange ? 32'h0
                                   : {mem[lane[3]], mem[lane[2]], mem[lane[1]], mem[lane[0]]};
          end
          readAck  <= !opWrite;
          writeAck <= opWrite;
          busError <= outOfRange;
          state    <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory has no reset; a reset during ACCESS still suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && opWrite && !outOfRange) begin
      for (int i = 0; i < 4; i++) begin
        mem[lane[i]] <= dataReg[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ram_controller.sv
// Self-checking bench for ram_controller: one instance with no wait states, one with three.
module tb_ram_controller;

  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;
`ifdef RAM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr0, din0, val0, addr3, din3, val3;
  logic        rd0, wr0, rack0, wack0, berr0;
  logic        rd3, wr3, rack3, wack3, berr3;

  always #5 clk = ~clk;

  ram_controller #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .ramAddress(addr0), .ramIn(din0),
    .readReq(rd0), .writeReq(wr0), .ramValue(val0),
    .readAck(rack0), .writeAck(wack0), .busError(berr0));

  ram_controller #(.ADDR_WIDTH(AW), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .ramAddress(addr3), .ramIn(din3),
    .readReq(rd3), .writeReq(wr3), .ramValue(val3),
    .readAck(rack3), .writeAck(wack3), .busError(berr3));

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  model [2][DEPTH];
  logic [31:0] lastRead [2];

  typedef struct {
    int          mode;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] expVal;
  } vecT;
  vecT vecs [9];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic bit isOob(input logic [31:0] a);
    return BOUNDS && (longint'(a) + 3 >= longint'(DEPTH));
  endfunction

  function automatic logic [31:0] modelRead(input int w, input logic [31:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = model[w][int'((a + 32'(i)) % DEPTH)];
    return r;
  endfunction

  task automatic setInputs(input int w, input logic [31:0] a, input logic [31:0] d, input logic r, input logic wq);
    if (w == 0) begin addr0 = a; din0 = d; rd0 = r; wr0 = wq; end
    else        begin addr3 = a; din3 = d; rd3 = r; wr3 = wq; end
  endtask

  task automatic sample(input int w, output logic [31:0] v, output logic ra, output logic wa, output logic be);
    if (w == 0) begin v = val0; ra = rack0; wa = wack0; be = berr0; end
    else        begin v = val3; ra = rack3; wa = wack3; be = berr3; end
  endtask

  // mode: 0 read, 1 write, 2 both requests high (write must win)
  task automatic applyStimulus(input int w, input int mode, input logic [31:0] a, input logic [31:0] d,
                               input string tag, output logic [31:0] got);
    bit          expWr  = (mode != 0);
    bit          expErr = isOob(a);
    int          expLat = (w == 0) ? 3 : 6;
    int          k;
    bit          seen;
    logic [31:0] v;
    logic        ra, wa, be;
    @(negedge clk);
    setInputs(w, a, d, mode != 1, mode != 0);
    @(posedge clk);
    @(negedge clk);
    setInputs(w, $urandom, $urandom, mode != 1, mode != 0);
    k = 1;
    seen = 0;
    while (!seen && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      sample(w, v, ra, wa, be);
      if (ra || wa) seen = 1;
    end
    setInputs(w, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput({tag, " latency"}, 32'(k), 32'(expLat));
    if (expWr) begin
      if (!expErr) for (int i = 0; i < 4; i++) model[w][int'((a + 32'(i)) % DEPTH)] = d[8*i +: 8];
    end else begin
      lastRead[w] = expErr ? 32'h0 : modelRead(w, a);
    end
    checkOutput({tag, " readAck"},  {31'd0, ra}, {31'd0, !expWr});
    checkOutput({tag, " writeAck"}, {31'd0, wa}, {31'd0, expWr});
    checkOutput({tag, " busError"}, {31'd0, be}, {31'd0, expErr});
    checkOutput({tag, " ramValue"}, v, lastRead[w]);
    @(posedge clk);
    #1;
    sample(w, v, ra, wa, be);
    checkOutput({tag, " ack clear"}, {29'd0, ra, wa, be}, 32'h0);
    got = v;
  endtask

  initial begin
    logic [31:0] got, v, a, d;
    logic        ra, wa, be;
    int          acks;

    vecs[0] = '{1, 32'h10, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1, 32'h21, 32'h11223344, 32'h0};
    vecs[3] = '{0, 32'h20, 32'h0,        32'h22334400};
    vecs[4] = '{0, 32'h22, 32'h0,        32'h00112233};
    vecs[5] = '{0, 32'h24, 32'h0,        32'h00000011};
    vecs[6] = '{2, 32'h40, 32'hA5A5A5A5, 32'h0};
    vecs[7] = '{0, 32'h40, 32'h0,        32'hA5A5A5A5};
    vecs[8] = '{0, 32'h12, 32'h0,        32'h0000DEAD};

    reset = 1'b1;
    setInputs(0, 32'h0, 32'h0, 1'b0, 1'b0);
    setInputs(1, 32'h0, 32'h0, 1'b0, 1'b0);
    lastRead[0] = 32'h0;
    lastRead[1] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      sample(w, v, ra, wa, be);
      checkOutput("reset ramValue", v, 32'h0);
      checkOutput("reset flags", {29'd0, ra, wa, be}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Three wait states: ack only after edge N+5.
    applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, "w3 write", got);
    applyStimulus(1, 0, 32'h10, 32'h0, "w3 read", got);
    checkOutput("w3 data", got, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) begin
      a = ($urandom % 512) * 4;
      d = $urandom;
      applyStimulus(1, 1, a, d, "w3 rnd write", got);
      applyStimulus(1, 0, a, 32'h0, "w3 rnd read", got);
      checkOutput("w3 rnd data", got, d);
    end

    for (int i = 0; i < DEPTH / 4; i++) applyStimulus(0, 1, 32'(i * 4), 32'h0, "fill", got);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, vecs[i].mode, vecs[i].addr, vecs[i].data, "vec", got);
      if (vecs[i].mode == 0) checkOutput("vec data", got, vecs[i].expVal);
    end

    applyStimulus(0, 1, 32'h7FC, 32'h04030201, "wrap w1", got);
    applyStimulus(0, 1, 32'h0,   32'h08070605, "wrap w2", got);
    applyStimulus(0, 0, 32'h7FE, 32'h0, "wrap read", got);
    checkOutput("wrap data", got, BOUNDS ? 32'h0 : 32'h06050403);
    applyStimulus(0, 0, 32'h80000010, 32'h0, "hi bits read", got);
    checkOutput("hi bits data", got, BOUNDS ? 32'h0 : 32'hDEADBEEF);

    // Reset while a write sits in BUSY: no ack, memory untouched.
    applyStimulus(0, 1, 32'h50, 32'hCAFEF00D, "pre write", got);
    applyStimulus(0, 0, 32'h50, 32'h0, "pre read", got);
    @(negedge clk);
    setInputs(0, 32'h50, 32'h12345678, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    setInputs(0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("abort ramValue", val0, 32'h0);
    lastRead[0] = 32'h0;
    lastRead[1] = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (rack0 || wack0 || berr0) acks++;
    end
    checkOutput("abort no ack", 32'(acks), 32'h0);
    applyStimulus(0, 0, 32'h50, 32'h0, "post abort read", got);
    checkOutput("post abort data", got, 32'hCAFEF00D);

    for (int i = 0; i < 300; i++) begin
      a = ($urandom % 4 == 0) ? $urandom : 32'($urandom % DEPTH);
      applyStimulus(0, int'($urandom % 3), a, $urandom, "rnd", got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
